// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared widths, types and reset constants for the MIPS register bank
package reg_bank_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO        = 5'd0;
    localparam reg_idx_t REG_SP          = 5'd29;
    localparam word_t    SP_INIT_DEFAULT = 32'd227;

    // $sp comes out of reset pointing at the top of the stack; everything else is cleared.
    function automatic word_t reset_value(reg_idx_t idx, word_t sp_init);
        return (idx == REG_SP) ? sp_init : '0;
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// rtl/reg_bank_if.sv - write-back and dual read bus between the datapath and the register bank
interface reg_bank_if;
    import reg_bank_pkg::*;

    logic     reg_write;
    reg_idx_t write_reg;
    word_t    write_data;
    reg_idx_t read_reg_1;
    reg_idx_t read_reg_2;
    word_t    read_data_1;
    word_t    read_data_2;

    modport master (
        output reg_write, write_reg, write_data, read_reg_1, read_reg_2,
        input  read_data_1, read_data_2
    );

    modport slave (
        input  reg_write, write_reg, write_data, read_reg_1, read_reg_2,
        output read_data_1, read_data_2
    );

endinterface

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - one combinational read port; $zero forcing and, with REG_BANK_WRITE_BYPASS_EN, write-through forwarding
module reg_read_port
    import reg_bank_pkg::*;
(
    output word_t    data_o,
    input  reg_idx_t idx_i,
    input  word_t    regs_i [NUM_REGS]
`ifdef REG_BANK_WRITE_BYPASS_EN
    ,
    input  logic     byp_en_i,
    input  reg_idx_t byp_idx_i,
    input  word_t    byp_data_i
`endif
);

    always_comb begin
        data_o = regs_i[idx_i];
`ifdef REG_BANK_WRITE_BYPASS_EN
        if (byp_en_i && (byp_idx_i == idx_i)) begin
            data_o = byp_data_i;
        end
`endif
        // Zero check last so no forwarding path can ever make $zero non-zero.
        if (idx_i == REG_ZERO) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - 32x32 register file, sync write / comb read; optional REG_BANK_WRITE_BYPASS_EN forwarding
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter word_t SP_INIT = SP_INIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    reg_bank_if.slave  bus
);

    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];
    logic  wr_en;

    assign wr_en = bus.reg_write && (bus.write_reg != REG_ZERO);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.write_reg] = bus.write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= reset_value(reg_idx_t'(i), SP_INIT);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REG_BANK_WRITE_BYPASS_EN
    // A write held off by reset must not leak onto the read ports either.
    logic byp_en;
    assign byp_en = wr_en && reset_n;
`endif

    reg_read_port u_rd1 (
        .data_o     (bus.read_data_1),
        .idx_i      (bus.read_reg_1),
        .regs_i     (regs_q)
`ifdef REG_BANK_WRITE_BYPASS_EN
        ,
        .byp_en_i   (byp_en),
        .byp_idx_i  (bus.write_reg),
        .byp_data_i (bus.write_data)
`endif
    );

    reg_read_port u_rd2 (
        .data_o     (bus.read_data_2),
        .idx_i      (bus.read_reg_2),
        .regs_i     (regs_q)
`ifdef REG_BANK_WRITE_BYPASS_EN
        ,
        .byp_en_i   (byp_en),
        .byp_idx_i  (bus.write_reg),
        .byp_data_i (bus.write_data)
`endif
    );

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - directed plus randomized check of reg_bank against an array model
module tb_reg_bank;
    import reg_bank_pkg::*;

    logic clk;
    logic reset_n;

    reg_bank_if bus ();

    reg_bank dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_total;
    int    n_pass;
    int    n_fail;
    word_t mdl [32];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mdl[29] = 32'd227;
    endtask

    // Architectural view: $zero reads 0; with forwarding a live write is seen early.
    function automatic word_t expect_rd(reg_idx_t idx);
        if (idx == 5'd0) return 32'd0;
`ifdef REG_BANK_WRITE_BYPASS_EN
        if (reset_n && bus.reg_write && bus.write_reg == idx) return bus.write_data;
`endif
        return mdl[idx];
    endfunction

    task automatic check(string tag, word_t obs, word_t exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reads(string tag, reg_idx_t i1, reg_idx_t i2);
        bus.read_reg_1 = i1;
        bus.read_reg_2 = i2;
        #1;
        check($sformatf("%s p1 r%0d", tag, i1), bus.read_data_1, expect_rd(i1));
        check($sformatf("%s p2 r%0d", tag, i2), bus.read_data_2, expect_rd(i2));
    endtask

    // Called just after a negedge: drive a write, let one rising edge take it, update model.
    task automatic do_write(logic we, reg_idx_t wr, word_t wd);
        bus.reg_write  = we;
        bus.write_reg  = wr;
        bus.write_data = wd;
        @(posedge clk);
        if (we && wr != 5'd0) mdl[wr] = wd;
        @(negedge clk);
        bus.reg_write = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        reset_n        = 1'b1;
        bus.reg_write  = 1'b0;
        bus.write_reg  = '0;
        bus.write_data = '0;
        bus.read_reg_1 = 5'd29;
        bus.read_reg_2 = 5'd0;
        model_reset();

        // Asynchronous reset before the first clock edge
        #2 reset_n = 1'b0;
        #1;
        check("async_rst sp", bus.read_data_1, 32'd227);
        check("async_rst zero", bus.read_data_2, 32'd0);
        for (int i = 0; i < 32; i++) check_reads("rst_scan", reg_idx_t'(i), reg_idx_t'(31 - i));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed write/read-back
        do_write(1'b1, 5'd8, 32'hDEADBEEF);
        do_write(1'b1, 5'd9, 32'd5);
        check_reads("wr_rb", 5'd8, 5'd9);
        check("wr_rb r8", bus.read_data_1, 32'hDEADBEEF);
        check("wr_rb r9", bus.read_data_2, 32'd5);
        check_reads("swap", 5'd9, 5'd8);
        check("swap r9", bus.read_data_1, 32'd5);
        check("swap r8", bus.read_data_2, 32'hDEADBEEF);

        do_write(1'b1, 5'd0, 32'hFFFFFFFF);
        check_reads("zero_prot", 5'd0, 5'd0);
        check("zero_prot lit", bus.read_data_1, 32'd0);

        do_write(1'b0, 5'd8, 32'd1);
        check_reads("gate", 5'd8, 5'd8);
        check("gate lit", bus.read_data_1, 32'hDEADBEEF);

        // Read during write of r8
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd8;
        bus.write_data = 32'd7;
        bus.read_reg_1 = 5'd8;
        #1;
`ifdef REG_BANK_WRITE_BYPASS_EN
        check("rdw before", bus.read_data_1, 32'd7);
`else
        check("rdw before", bus.read_data_1, 32'hDEADBEEF);
`endif
        @(posedge clk);
        mdl[8] = 32'd7;
        #1;
        check("rdw after", bus.read_data_1, 32'd7);
        @(negedge clk);
        bus.reg_write = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            bus.reg_write  = 1'($urandom_range(0, 1));
            bus.write_reg  = reg_idx_t'($urandom_range(0, 31));
            bus.write_data = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                bus.read_reg_1 = bus.write_reg;
            end else begin
                bus.read_reg_1 = reg_idx_t'($urandom_range(0, 31));
            end
            bus.read_reg_2 = reg_idx_t'($urandom_range(0, 31));
            check_reads("rand", bus.read_reg_1, bus.read_reg_2);
            @(posedge clk);
            if (bus.reg_write && bus.write_reg != 5'd0) mdl[bus.write_reg] = bus.write_data;
            @(negedge clk);
        end
        bus.reg_write = 1'b0;
        check_reads("rand_end", 5'd29, 5'd31);

        // Reset asserted during a write to $sp
        do_write(1'b1, 5'd8, 32'h0BAD_CAFE);
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd29;
        bus.write_data = 32'd100;
        bus.read_reg_1 = 5'd29;
        bus.read_reg_2 = 5'd8;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_wr sp now", bus.read_data_1, 32'd227);
        check("rst_wr r8 now", bus.read_data_2, 32'd0);
        @(posedge clk);
        #1;
        check("rst_wr sp edge", bus.read_data_1, 32'd227);
        @(negedge clk);
        bus.reg_write = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check_reads("post_rst", 5'd29, 5'd8);

        // $sp is an ordinary register afterwards
        do_write(1'b1, 5'd29, 32'h0000_1234);
        check_reads("sp_wr", 5'd29, 5'd29);
        check("sp_wr lit", bus.read_data_2, 32'h0000_1234);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
